uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares a single uart_tx serializer between NUM_REQ byte producers, for example LiDAR command, debug and telemetry sources. Producers present bytes on independent valid/ready ports, and grants rotate round-robin. Each granted byte is optionally preceded by a tag byte that identifies its source. The block drives uart_tx's data_i/start_i, waits for done_o, and aborts any transfer whose done_o is lost.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
TAG_EN, 1, 1 = send tag byte {4'hA, id[3:0]} before each data byte; 0 = data byte only.
TIMEOUT_CYCLES, 10416, watchdog limit in clk cycles per byte, measured from start pulse to done (12 x 868 at 115200 baud, 100 MHz).

Ports:
clk  in  1  system clock.
rst_n_i  in  1  asynchronous active-low reset.
req_valid_i  in  NUM_REQ  per-requester byte valid.
req_data_i  in  8*NUM_REQ  requester k byte on [8k+7:8k]; held stable while valid until accepted.
req_ready_o  out  NUM_REQ  one-hot accept; the byte transfers on the clk edge where valid&ready.
utx_data_o  out  8  byte to uart_tx data_i.
utx_start_o  out  1  one-cycle start pulse to uart_tx start_i.
utx_done_i  in  1  uart_tx done_o; one-cycle pulse at end of stop bit.
busy_o  out  1  high in every state except IDLE.
grant_id_o  out  max(1,$clog2(NUM_REQ))  id of the current or last granted requester.
timeout_o  out  1  one-cycle pulse when the watchdog aborts a transfer.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n_i is asynchronous and active-low.
- Reset values: state IDLE; utx_data_o=0, utx_start_o=0, busy_o=0, grant_id_o=0, timeout_o=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority. req_ready_o is forced to 0 while rst_n_i is low.
- FSM states: IDLE, START_TAG, WAIT_TAG, START_DATA, WAIT_DATA.
- IDLE:
  - k = first requester with valid set, searching last+1, last+2, ... with wrap-around modulo NUM_REQ.
  - req_ready_o = onehot(k), combinational, only in IDLE.
  - At that edge: latch data byte, grant_id_o<=k, last<=k.
  - Next state: START_TAG if TAG_EN, else START_DATA.
  - No valid: stay in IDLE, req_ready_o=0.
- START_TAG: utx_data_o={4'hA,k[3:0]}, utx_start_o=1 for exactly this one cycle; load watchdog with TIMEOUT_CYCLES; go to WAIT_TAG.
- WAIT_TAG:
  - utx_done_i=1 -> START_DATA.
  - Watchdog reaches 0 first -> timeout_o pulse; data byte discarded; go to IDLE.
- START_DATA: utx_data_o=latched byte, utx_start_o=1 for one cycle; reload watchdog; go to WAIT_DATA.
- WAIT_DATA: utx_done_i=1 -> IDLE. Watchdog expiry -> timeout_o pulse, then IDLE.
- utx_data_o holds its value after a start until the next start.
- Latency:
  - Accept edge to first utx_start_o: 1 cycle.
  - done to data start: 1 cycle.
  - done of the last byte to next accept: 1 cycle (IDLE lasts at least 1 cycle).
- Watchdog: down-counter decremented each WAIT cycle.
  - done and expiry in the same cycle: done wins, no timeout.
- utx_done_i is ignored in IDLE and START states; stray pulses have no effect.
- Single active requester: it is granted on every IDLE visit (no starvation of itself). Multiple active requesters: strict rotation, one byte per grant.
- A requester dropping valid before accept is legal; the byte is simply not sent.
- Reset asserted mid-transfer: immediate return to reset values. A partially sent byte on the line is uart_tx's concern; this block does not resend it.

Test Plan:
- Single request: TAG_EN=1, req 2 valid with 8'hFF -> req_ready_o=4'b0100 for one cycle. Starts carry 8'hA2 then 8'hFF, with the second start exactly 1 cycle after the first done. busy_o falls 1 cycle after the second done.
- Round robin: reqs 0,1,3 continuously valid with 8'h10, 8'h11, 8'h13 -> grant order 0,1,3,0,1,3. Data bytes follow that order, each preceded by its tag (A0, A1, A3).
- TAG_EN=0: req 0 with 8'b10000001 -> exactly one start, utx_data_o=8'h81, then back to IDLE.
- Watchdog: TIMEOUT_CYCLES=50, utx_done_i never asserted -> timeout_o pulses 50 cycles after the tag start. No data start occurs; the block returns to IDLE and grants the next valid requester.
- Done/expiry collision and stray done: done on the exact expiry cycle -> no timeout_o, transfer proceeds. Done pulse in IDLE -> no state change, no start.
- Reset mid-WAIT_DATA: assert rst_n_i=0 asynchronously -> all outputs 0 within the same cycle. After release, requester 0 wins when all requesters are valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
// Each grant optionally sends a source tag {4'hA, id} before the data byte, with a per-byte watchdog.
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TAG_EN         = 1,
  parameter  int TIMEOUT_CYCLES = 10416,
  localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             utx_data_o,
  output logic                   utx_start_o,
  input  logic                   utx_done_i,
  output logic                   busy_o,
  output logic [IDW-1:0]         grant_id_o,
  output logic                   timeout_o
);

  localparam int             WDW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LOAD  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_TAG  = 3'd1,
    S_WAIT_TAG   = 3'd2,
    S_START_DATA = 3'd3,
    S_WAIT_DATA  = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_last;
  logic [IDW-1:0]     r_grant;
  logic [7:0]         r_byte;
  logic [7:0]         r_data;
  logic               r_start;
  logic               r_busy;
  logic               r_timeout;
  logic [WDW-1:0]     r_wd;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [IDW-1:0]       w_off;
  logic [IDW:0]         w_sum;
  logic [IDW-1:0]       w_k;
  logic                 w_any;
  logic [8*NUM_REQ-1:0] w_data_sh;
  logic [7:0]           w_byte;
  logic [7:0]           w_tag;
  logic                 w_expired;

  // Rotate the valids so bit 0 is the requester right after the last grant.
  assign w_dbl = {req_valid_i, req_valid_i};
  assign w_rot = w_dbl >> ({1'b0, r_last} + (IDW+1)'(1));
  assign w_any = |req_valid_i;

  // Lowest set bit of the rotated valids is the round-robin offset.
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_off = w_rot[i] ? IDW'(i) : w_off;
    end
  end

  assign w_sum       = {1'b0, r_last} + (IDW+1)'(1) + {1'b0, w_off};
  assign w_k         = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : w_sum[IDW-1:0];
  assign w_data_sh   = req_data_i >> {w_k, 3'b000};
  assign w_byte      = w_data_sh[7:0];
  assign w_tag       = {4'hA, 4'(w_k)};
  assign w_expired   = (r_wd <= WDW'(1));
  assign req_ready_o = (rst_n_i && (r_state == S_IDLE) && w_any) ?
                       (NUM_REQ'(1'b1) << w_k) : '0;

  assign utx_data_o  = r_data;
  assign utx_start_o = r_start;
  assign busy_o      = r_busy;
  assign grant_id_o  = r_grant;
  assign timeout_o   = r_timeout;

  // Arbitration FSM; outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_last    <= LAST_RST;
      r_grant   <= '0;
      r_byte    <= 8'h00;
      r_data    <= 8'h00;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_byte  <= w_byte;
            r_grant <= w_k;
            r_last  <= w_k;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            if (TAG_EN != 0) begin
              r_data  <= w_tag;
              r_state <= S_START_TAG;
            end else begin
              r_data  <= w_byte;
              r_state <= S_START_DATA;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START_TAG: begin
          r_wd    <= WD_LOAD;
          r_state <= S_WAIT_TAG;
        end
        S_WAIT_TAG: begin
          // done on the expiry cycle still counts as a completed byte
          if (utx_done_i) begin
            r_data  <= r_byte;
            r_start <= 1'b1;
            r_state <= S_START_DATA;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd - WDW'(1);
          end
        end
        S_START_DATA: begin
          r_wd    <= WD_LOAD;
          r_state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (utx_done_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd - WDW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
